rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that produces a registered one-hot select for the downstream one-hot data mux in the MMU request path.
- Requesters are the table-walker, the ATC-fill path, the CPU-side translation port and the debug/register port.
- Holds each grant stable until the downstream stage accepts it, so the mux select never changes mid-transfer.
- Supports a lock input so read-modify-write sequences (TAS/CAS descriptor updates) keep the same owner across beats.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- IDXW, $clog2(N), width of the binary grant index; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  per-requester request; bit i high means requester i wants the mux.
- lock  input  1  sampled on acceptance; when high, the current owner keeps the grant for the next transfer.
- grant_onehot  output  N  registered one-hot select to the downstream mux; all-zero when idle.
- grant_idx  output  IDXW  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  high when grant_onehot is non-zero.
- grant_ready  input  1  downstream accepts the current grant; a transfer completes on grant_valid && grant_ready.
- locked  output  1  high while the current grant is held by lock.

Behaviour:
- Reset (async assert, sync release): grant_onehot=0, grant_idx=0, grant_valid=0, locked=0, state=IDLE. The priority pointer resets to 0, so requester 0 has highest priority first.
- Priority rule: search starts at pointer ptr and wraps modulo N. The first set req bit at or after ptr wins.
- States: IDLE, GRANT, HOLD_LOCK.
- IDLE:
  - If any req bit is set, the winner is registered and the block moves to GRANT.
  - Latency: req high at edge t gives grant_valid high after edge t+1.
- GRANT:
  - grant_onehot and grant_idx stay constant until acceptance.
  - Changes to other req bits have no effect.
- Acceptance with lock=0:
  - ptr becomes winner+1, wrapping from N-1 to 0.
  - In the same edge, a new winner is computed from the current req using the updated ptr, excluding the bit just served only if it is the sole request and was not re-asserted. Re-asserted means req[g] is still high; in that case it is re-granted.
  - If a winner exists, stay in GRANT with the new winner (back-to-back, one grant per cycle). Otherwise go to IDLE with outputs zeroed.
- Acceptance with lock=1:
  - Go to HOLD_LOCK with the same grant, locked=1.
  - ptr is unchanged.
- HOLD_LOCK:
  - Same grant held.
  - Each acceptance re-samples lock. Acceptance with lock=0 releases exactly as the GRANT release rule and clears locked in the same edge.
  - Other requests are ignored while locked.
- Request withdrawal: if req[grant_idx]=0 while valid and not accepted (GRANT or HOLD_LOCK):
  - Next edge the grant is dropped: IDLE, outputs 0, locked=0, ptr unchanged.
  - If acceptance and withdrawal coincide, acceptance takes precedence.
- Stall: while grant_ready is low, all outputs and ptr are frozen (apart from the withdrawal rule).
- Invariants:
  - grant_onehot is always zero or exactly one bit set.
  - grant_onehot[grant_idx]==grant_valid.
  - locked implies grant_valid.
- Reset mid-operation: outputs clear immediately on rst assert, with no waiting for a clock edge. A locked sequence is abandoned.

Test Plan:
- Reset and single request: rst pulse, then req=4'b0100 at edge 1 → grant_onehot=4'b0100, grant_idx=2, grant_valid=1 after edge 2. With grant_ready=1 held, the grant repeats each cycle for requester 2; ptr wraps correctly.
- Full contention, N=4: req=4'b1111, grant_ready=1 constant → grant sequence 0,1,2,3,0,1 on consecutive cycles with no idle gaps.
- Stall: req=4'b0011 and grant 0 issued, grant_ready=0 for 5 cycles → grant_onehot stays 4'b0001 while req[1] is high. On grant_ready=1 the next grant is 4'b0010.
- Lock: req=4'b0101, grant 0 accepted with lock=1 → locked=1 and grant 0 is held for 3 accepts while req[2] waits. Release with lock=0 → next grant is 4'b0100, locked=0.
- Withdrawal and async reset:
  - With grant 3 held and grant_ready=0, drop req[3] → grant_valid=0 next cycle and ptr unchanged; re-assert req=4'b1001 → grant 3.
  - Assert rst between edges while granted → all outputs 0 before the next edge.
- Boundary, N=2 and N=16 builds: only the top bit requesting → grant_idx=N-1. Wrap to index 0 on the next contention. Invariants checked by assertion every cycle.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter driving a registered one-hot mux select; grants are held
// until accepted, optionally across several transfers under lock.
module rr_grant_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            lock,
    output logic [N-1:0]    grant_onehot,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    input  logic            grant_ready,
    output logic            locked
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD_LOCK
    } state_t;

    state_t          state, state_n;
    logic [IDXW-1:0] ptr, ptr_n;
    logic [IDXW-1:0] idx_n;
    logic [N-1:0]    onehot_n;
    logic [IDXW-1:0] rel_ptr;
    logic            idle_found, rel_found;
    logic [IDXW-1:0] idle_idx, rel_idx;

    // First set bit at or above p wins; otherwise the lowest set bit (wrap-around).
    function automatic logic [IDXW:0] pick(input logic [N-1:0] r, input logic [IDXW-1:0] p);
        logic            found_hi;
        logic            found_any;
        logic [IDXW-1:0] idx_hi;
        logic [IDXW-1:0] idx_any;
        found_hi  = 1'b0;
        found_any = 1'b0;
        idx_hi    = '0;
        idx_any   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r[i] && !found_any) begin
                found_any = 1'b1;
                idx_any   = IDXW'(i);
            end
            if (r[i] && (i >= 32'(p)) && !found_hi) begin
                found_hi = 1'b1;
                idx_hi   = IDXW'(i);
            end
        end
        return found_hi ? {1'b1, idx_hi} : {found_any, idx_any};
    endfunction

    always_comb begin
        rel_ptr                 = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + 1'b1;
        {idle_found, idle_idx}  = pick(req, ptr);
        {rel_found, rel_idx}    = pick(req, rel_ptr);
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        idx_n    = grant_idx;
        onehot_n = '0;
        case (state)
            IDLE: begin
                if (idle_found) begin
                    state_n = GRANT;
                    idx_n   = idle_idx;
                end
            end
            GRANT, HOLD_LOCK: begin
                // Acceptance outranks withdrawal of the granted request.
                if (grant_ready) begin
                    if (lock) begin
                        state_n = HOLD_LOCK;
                    end else begin
                        ptr_n = rel_ptr;
                        if (rel_found) begin
                            state_n = GRANT;
                            idx_n   = rel_idx;
                        end else begin
                            state_n = IDLE;
                            idx_n   = '0;
                        end
                    end
                end else if (!req[grant_idx]) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
        if (state_n != IDLE) begin
            onehot_n[idx_n] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_onehot <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            grant_onehot <= onehot_n;
            grant_idx    <= idx_n;
            grant_valid  <= (state_n != IDLE);
            locked       <= (state_n == HOLD_LOCK);
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: N=4, N=2 and N=16 instances against directed
// expectations and a behavioural round-robin model.
module tb_rr_grant_arbiter;

    logic        clk;
    logic        rst;
    logic        lock;
    logic        ready;

    logic [3:0]  req4, oh4;
    logic [1:0]  idx4;
    logic        v4, l4;
    logic [1:0]  req2, oh2;
    logic [0:0]  idx2;
    logic        v2, l2;
    logic [15:0] req16, oh16;
    logic [3:0]  idx16;
    logic        v16, l16;

    int total = 0;
    int bad   = 0;

    int m_valid[3];
    int m_idx[3];
    int m_ptr[3];
    int m_locked[3];
    int nn[3] = '{4, 2, 16};

    rr_grant_arbiter #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .lock(lock),
        .grant_onehot(oh4), .grant_idx(idx4), .grant_valid(v4),
        .grant_ready(ready), .locked(l4)
    );

    rr_grant_arbiter #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .lock(lock),
        .grant_onehot(oh2), .grant_idx(idx2), .grant_valid(v2),
        .grant_ready(ready), .locked(l2)
    );

    rr_grant_arbiter #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .req(req16), .lock(lock),
        .grant_onehot(oh16), .grant_idx(idx16), .grant_valid(v16),
        .grant_ready(ready), .locked(l16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain round-robin search over an integer pointer.
    function automatic int pick(int n, logic [15:0] r, int p);
        int c;
        for (int j = 0; j < n; j++) begin
            c = (p + j) % n;
            if (((r >> c) & 16'h1) != 16'h0) return c;
        end
        return -1;
    endfunction

    function automatic logic [15:0] req_of(int k);
        if (k == 0) return {12'h0, req4};
        if (k == 1) return {14'h0, req2};
        return req16;
    endfunction

    task automatic model_step();
        logic [15:0] r;
        int          w;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_valid[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_locked[k] = 0;
            end else begin
                r = req_of(k);
                if (m_valid[k] == 0) begin
                    w = pick(nn[k], r, m_ptr[k]);
                    if (w >= 0) begin
                        m_valid[k] = 1;
                        m_idx[k]   = w;
                    end
                end else if (ready) begin
                    if (lock) begin
                        m_locked[k] = 1;
                    end else begin
                        m_ptr[k]    = (m_idx[k] + 1) % nn[k];
                        m_locked[k] = 0;
                        w = pick(nn[k], r, m_ptr[k]);
                        if (w >= 0) m_idx[k] = w;
                        else begin m_valid[k] = 0; m_idx[k] = 0; end
                    end
                end else if (((r >> m_idx[k]) & 16'h1) == 16'h0) begin
                    m_valid[k] = 0; m_idx[k] = 0; m_locked[k] = 0;
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_locked[k] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Structural invariants on every instance, every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                total++;
                if (!$onehot0(oh4) || oh4[idx4] !== v4 || (l4 && !v4) ||
                    !$onehot0(oh2) || oh2[idx2] !== v2 || (l2 && !v2) ||
                    !$onehot0(oh16) || oh16[idx16] !== v16 || (l16 && !v16)) begin
                    bad++;
                    $display("FAIL invariant t=%0t: oh4=%b idx4=%0d v4=%b l4=%b oh2=%b idx2=%0d v2=%b l2=%b oh16=%h idx16=%0d v16=%b l16=%b",
                             $time, oh4, idx4, v4, l4, oh2, idx2, v2, l2, oh16, idx16, v16, l16);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_all();
        req4 = '0; req2 = '0; req16 = '0; lock = 1'b0; ready = 1'b1;
        tick(); tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; lock = 1'b0; ready = 1'b0;
        req4 = '0; req2 = '0; req16 = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if (oh4 !== 4'b0 || idx4 !== 2'd0 || v4 !== 1'b0 || l4 !== 1'b0 ||
            oh2 !== 2'b0 || v2 !== 1'b0 || oh16 !== 16'h0 || v16 !== 1'b0) begin
            bad++;
            $display("FAIL reset: oh4=%b idx4=%0d v4=%b l4=%b oh2=%b v2=%b oh16=%h v16=%b, want all zero",
                     oh4, idx4, v4, l4, oh2, v2, oh16, v16);
        end
    endtask

    task automatic test_single();
        req4 = 4'b0100; ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (oh4 !== 4'b0100 || idx4 !== 2'd2 || v4 !== 1'b1 || l4 !== 1'b0) begin
                bad++;
                $display("FAIL single c=%0d: oh=%b idx=%0d v=%b l=%b, want oh=0100 idx=2 v=1 l=0", c, oh4, idx4, v4, l4);
            end
        end
        req4 = '0;
        tick();
        total++;
        if (v4 !== 1'b0 || oh4 !== 4'b0) begin
            bad++;
            $display("FAIL single_idle: oh=%b v=%b, want oh=0000 v=0", oh4, v4);
        end
        idle_all();
    endtask

    task automatic test_contention();
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        reset_pulse();
        req4 = 4'b1111; ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (v4 !== 1'b1 || int'(idx4) != exp_seq[c] || oh4 !== (4'b0001 << exp_seq[c])) begin
                bad++;
                $display("FAIL contention c=%0d: idx=%0d oh=%b v=%b, want idx=%0d v=1", c, idx4, oh4, v4, exp_seq[c]);
            end
        end
        idle_all();
    endtask

    task automatic test_stall();
        reset_pulse();
        req4 = 4'b0011; ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (oh4 !== 4'b0001 || idx4 !== 2'd0 || v4 !== 1'b1) begin
                bad++;
                $display("FAIL stall c=%0d: oh=%b idx=%0d v=%b, want oh=0001 idx=0 v=1", c, oh4, idx4, v4);
            end
        end
        ready = 1'b1;
        tick();
        total++;
        if (oh4 !== 4'b0010 || idx4 !== 2'd1) begin
            bad++;
            $display("FAIL stall_release: oh=%b idx=%0d, want oh=0010 idx=1", oh4, idx4);
        end
        idle_all();
    endtask

    task automatic test_lock();
        reset_pulse();
        req4 = 4'b0101; ready = 1'b1; lock = 1'b1;
        tick();
        total++;
        if (oh4 !== 4'b0001 || l4 !== 1'b0) begin
            bad++;
            $display("FAIL lock_first: oh=%b l=%b, want oh=0001 l=0", oh4, l4);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (oh4 !== 4'b0001 || idx4 !== 2'd0 || l4 !== 1'b1 || v4 !== 1'b1) begin
                bad++;
                $display("FAIL lock_hold c=%0d: oh=%b idx=%0d l=%b v=%b, want oh=0001 idx=0 l=1 v=1", c, oh4, idx4, l4, v4);
            end
        end
        lock = 1'b0;
        tick();
        total++;
        if (oh4 !== 4'b0100 || idx4 !== 2'd2 || l4 !== 1'b0) begin
            bad++;
            $display("FAIL lock_release: oh=%b idx=%0d l=%b, want oh=0100 idx=2 l=0", oh4, idx4, l4);
        end
        idle_all();
    endtask

    task automatic test_withdraw_reset();
        reset_pulse();
        req4 = 4'b0100; ready = 1'b1;
        tick();
        req4 = 4'b1000;
        tick();
        total++;
        if (oh4 !== 4'b1000 || idx4 !== 2'd3) begin
            bad++;
            $display("FAIL withdraw_setup: oh=%b idx=%0d, want oh=1000 idx=3", oh4, idx4);
        end
        ready = 1'b0;
        tick();
        req4 = 4'b0000;
        tick();
        total++;
        if (v4 !== 1'b0 || oh4 !== 4'b0 || idx4 !== 2'd0 || l4 !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_drop: oh=%b idx=%0d v=%b l=%b, want all zero", oh4, idx4, v4, l4);
        end
        req4 = 4'b1001;
        tick();
        total++;
        if (oh4 !== 4'b1000 || idx4 !== 2'd3 || v4 !== 1'b1) begin
            bad++;
            $display("FAIL withdraw_ptr: oh=%b idx=%0d v=%b, want oh=1000 idx=3 v=1", oh4, idx4, v4);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (oh4 !== 4'b0 || idx4 !== 2'd0 || v4 !== 1'b0 || l4 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: oh=%b idx=%0d v=%b l=%b, want all zero before edge", oh4, idx4, v4, l4);
        end
        tick();
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_boundary();
        reset_pulse();
        req2 = 2'b10; req16 = 16'h8000; ready = 1'b1;
        tick();
        total++;
        if (idx2 !== 1'b1 || oh2 !== 2'b10 || idx16 !== 4'd15 || oh16 !== 16'h8000 || v2 !== 1'b1 || v16 !== 1'b1) begin
            bad++;
            $display("FAIL boundary_top: idx2=%0d oh2=%b idx16=%0d oh16=%h, want idx2=1 idx16=15", idx2, oh2, idx16, oh16);
        end
        req2 = 2'b11; req16 = 16'h8001;
        tick();
        total++;
        if (idx2 !== 1'b0 || oh2 !== 2'b01 || idx16 !== 4'd0 || oh16 !== 16'h0001) begin
            bad++;
            $display("FAIL boundary_wrap: idx2=%0d oh2=%b idx16=%0d oh16=%h, want idx2=0 idx16=0", idx2, oh2, idx16, oh16);
        end
        idle_all();
    endtask

    task automatic test_random();
        logic [15:0] obs_oh, exp_oh;
        int          obs_idx, obs_v, obs_l;
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (k == 0) begin obs_oh = 16'(oh4);  obs_idx = int'(idx4);  obs_v = int'(v4);  obs_l = int'(l4);  end
                else if (k == 1) begin obs_oh = 16'(oh2); obs_idx = int'(idx2); obs_v = int'(v2); obs_l = int'(l2); end
                else begin obs_oh = oh16; obs_idx = int'(idx16); obs_v = int'(v16); obs_l = int'(l16); end
                exp_oh = (m_valid[k] != 0) ? (16'h1 << m_idx[k]) : 16'h0;
                total++;
                if (obs_oh !== exp_oh || obs_idx != m_idx[k] || obs_v != m_valid[k] || obs_l != m_locked[k]) begin
                    bad++;
                    $display("FAIL random c=%0d n=%0d: oh=%h idx=%0d v=%0d l=%0d, want oh=%h idx=%0d v=%0d l=%0d",
                             c, nn[k], obs_oh, obs_idx, obs_v, obs_l, exp_oh, m_idx[k], m_valid[k], m_locked[k]);
                end
            end
            req4  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            req2  = 2'($urandom);
            req16 = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'(1 << $urandom_range(0, 15));
            lock  = ($urandom_range(0, 2) == 0);
            ready = ($urandom_range(0, 3) != 0);
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_lock();
        test_withdraw_reset();
        test_boundary();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
